wb_stage: RTL and testbench

- Writeback stage of the RISC-V pipeline, directly upstream of the register file; drives its write port (writeEnable, writeAddr, writeDate).
- Accepts one retiring instruction per cycle from the MEM stage.
- ALU results are committed after one cycle. Loads wait for the data-memory response, then are byte/half aligned and sign- or zero-extended before commit.
- Applies back-pressure to MEM while a load is outstanding.

---
 rtl/wb_stage_if.sv | 29 ++
 rtl/wb_stage.sv | 89 ++++++++
 tb/tb_wb_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-writeback handshake, load response and register-file write port.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5
);
  logic inValid;
  logic inReady;
  logic regWrite;
  logic memToReg;
  logic [2:0] funct3;
  logic [REG_ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] aluResult;
  logic memRespValid;
  logic [DATA_W-1:0] memRespData;
  logic flush;
  logic writeEnable;
  logic [REG_ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeDate;
  logic loadMisaligned;
  logic memTimeout;
  modport master (
    output inValid, regWrite, memToReg, funct3, rdAddr, aluResult, memRespValid, memRespData, flush,
    input inReady, writeEnable, writeAddr, writeDate, loadMisaligned, memTimeout
  );
  modport slave (
    input inValid, regWrite, memToReg, funct3, rdAddr, aluResult, memRespValid, memRespData, flush,
    output inReady, writeEnable, writeAddr, writeDate, loadMisaligned, memTimeout
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage; commits ALU results next cycle, waits for and aligns load data.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  wb_stage_if.slave bus
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [REG_ADDR_W-1:0] cap_rd;
  logic cap_we;
  logic [2:0] cap_f3;
  logic [1:0] cap_off;
  logic accept, mis, timeout;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [DATA_W-1:0] load_data;
  assign accept = bus.inValid && bus.inReady && !bus.flush;
  assign cnt_nxt = cnt + 16'd1;
  assign timeout = cnt_nxt == 16'(TIMEOUT);
  // unsupported funct3 encodings fall through to misaligned
  assign mis = (bus.funct3 == 3'b000 || bus.funct3 == 3'b100) ? 1'b0 :
               (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) ? bus.aluResult[0] :
               (bus.funct3 == 3'b010) ? |bus.aluResult[1:0] : 1'b1;
  assign lb = bus.memRespData[{cap_off, 3'b000} +: 8];
  assign lh = cap_off[1] ? bus.memRespData[31:16] : bus.memRespData[15:0];
  assign load_data = cap_f3 == 3'b000 ? {{(DATA_W-8){lb[7]}}, lb} :
                     cap_f3 == 3'b001 ? {{(DATA_W-16){lh[15]}}, lh} :
                     cap_f3 == 3'b100 ? {{(DATA_W-8){1'b0}}, lb} :
                     cap_f3 == 3'b101 ? {{(DATA_W-16){1'b0}}, lh} : bus.memRespData;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = (accept && bus.memToReg && !mis) ? WAIT_MEM : IDLE;
    else state_nxt = (bus.flush || bus.memRespValid || timeout) ? IDLE : WAIT_MEM;
  end
  always_comb bus.inReady = state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.writeEnable <= 1'b0;
      bus.writeAddr <= '0;
      bus.writeDate <= '0;
      bus.loadMisaligned <= 1'b0;
      bus.memTimeout <= 1'b0;
      cnt <= '0;
      cap_rd <= '0;
      cap_we <= 1'b0;
      cap_f3 <= '0;
      cap_off <= '0;
    end else begin
      bus.writeEnable <= 1'b0;
      bus.loadMisaligned <= 1'b0;
      bus.memTimeout <= 1'b0;
      if (state == IDLE && accept) begin
        if (!bus.memToReg) begin
          // address/data only move on a real write so they hold otherwise
          if (bus.regWrite && |bus.rdAddr) begin
            bus.writeEnable <= 1'b1;
            bus.writeAddr <= bus.rdAddr;
            bus.writeDate <= bus.aluResult;
          end
        end else if (mis) bus.loadMisaligned <= 1'b1;
        else begin
          cap_rd <= bus.rdAddr;
          cap_we <= bus.regWrite;
          cap_f3 <= bus.funct3;
          cap_off <= bus.aluResult[1:0];
          cnt <= '0;
        end
      end
      if (state == WAIT_MEM && !bus.flush) begin
        if (bus.memRespValid) begin
          if (cap_we && |cap_rd) begin
            bus.writeEnable <= 1'b1;
            bus.writeAddr <= cap_rd;
            bus.writeDate <= load_data;
          end
        end else if (timeout) bus.memTimeout <= 1'b1;
        else cnt <= cnt_nxt;
      end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors with hand-computed expectations for wb_stage.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tot = 0;
  int n_pass = 0;
  wb_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();
  wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic alu(input logic [4:0] rd, input logic [31:0] v);
    bus.inValid = 1'b1;
    bus.memToReg = 1'b0;
    bus.regWrite = 1'b1;
    bus.rdAddr = rd;
    bus.aluResult = v;
  endtask
  task automatic issue_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr);
    bus.inValid = 1'b1;
    bus.memToReg = 1'b1;
    bus.regWrite = 1'b1;
    bus.funct3 = f3;
    bus.rdAddr = rd;
    bus.aluResult = addr;
    cyc;
    bus.inValid = 1'b0;
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                         input int lat, input logic [31:0] word, input logic [31:0] exp);
    issue_load(f3, rd, addr);
    for (int i = 1; i <= lat; i++) begin
      bus.memRespValid = (i == lat);
      bus.memRespData = word;
      chk({tag, "_busy"}, {31'd0, bus.inReady}, 32'd0);
      cyc;
    end
    bus.memRespValid = 1'b0;
    chk({tag, "_we"}, {31'd0, bus.writeEnable}, 32'd1);
    chk({tag, "_addr"}, {27'd0, bus.writeAddr}, {27'd0, rd});
    chk({tag, "_data"}, bus.writeDate, exp);
    chk({tag, "_rdy"}, {31'd0, bus.inReady}, 32'd1);
    cyc;
    chk({tag, "_pulse"}, {31'd0, bus.writeEnable}, 32'd0);
  endtask
  task automatic do_mis(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    issue_load(f3, 5'd12, addr);
    chk({tag, "_mis"}, {31'd0, bus.loadMisaligned}, 32'd1);
    chk({tag, "_we"}, {31'd0, bus.writeEnable}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, bus.inReady}, 32'd1);
    cyc;
    chk({tag, "_mis_end"}, {31'd0, bus.loadMisaligned}, 32'd0);
  endtask
  initial begin
    bus.inValid = 1'b0;
    bus.regWrite = 1'b0;
    bus.memToReg = 1'b0;
    bus.funct3 = 3'b000;
    bus.rdAddr = '0;
    bus.aluResult = '0;
    bus.memRespValid = 1'b0;
    bus.memRespData = '0;
    bus.flush = 1'b0;
    #3;
    chk("rst_we", {31'd0, bus.writeEnable}, 32'd0);
    chk("rst_data", bus.writeDate, 32'd0);
    chk("rst_mis", {31'd0, bus.loadMisaligned}, 32'd0);
    chk("rst_to", {31'd0, bus.memTimeout}, 32'd0);
    chk("rst_rdy", {31'd0, bus.inReady}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc;
    // back-to-back ALU commits
    alu(5'd5, 32'h12345678);
    chk("alu0_idle", {31'd0, bus.writeEnable}, 32'd0);
    cyc;
    chk("alu1_we", {31'd0, bus.writeEnable}, 32'd1);
    chk("alu1_addr", {27'd0, bus.writeAddr}, 32'd5);
    chk("alu1_data", bus.writeDate, 32'h12345678);
    alu(5'd6, 32'hDEADBEEF);
    cyc;
    chk("alu2_we", {31'd0, bus.writeEnable}, 32'd1);
    chk("alu2_addr", {27'd0, bus.writeAddr}, 32'd6);
    chk("alu2_data", bus.writeDate, 32'hDEADBEEF);
    alu(5'd0, 32'hFFFFFFFF);
    cyc;
    bus.inValid = 1'b0;
    chk("x0_we", {31'd0, bus.writeEnable}, 32'd0);
    chk("x0_hold", bus.writeDate, 32'hDEADBEEF);
    // loads: lane select and extension
    do_load("lb", 3'b000, 5'd7, 32'h1003, 4, 32'h80FF0000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 5'd7, 32'h1003, 4, 32'h80FF0000, 32'h00000080);
    do_load("lh", 3'b001, 5'd8, 32'h2002, 2, 32'h80011234, 32'hFFFF8001);
    do_load("lhu", 3'b101, 5'd8, 32'h2002, 1, 32'h80011234, 32'h00008001);
    do_load("lh0", 3'b001, 5'd3, 32'h2000, 1, 32'h80019234, 32'hFFFF9234);
    do_load("lb0", 3'b000, 5'd4, 32'h2000, 3, 32'h80011234, 32'h00000034);
    do_load("lw", 3'b010, 5'd9, 32'h3000, 2, 32'h80011234, 32'h80011234);
    do_mis("lh_odd", 3'b001, 32'h1001);
    do_mis("lw_off2", 3'b010, 32'h1002);
    do_mis("f3_011", 3'b011, 32'h1000);
    // timeout after 8 wait cycles, then a late response is ignored
    issue_load(3'b010, 5'd9, 32'h4000);
    for (int i = 0; i < 8; i++) begin
      chk("to_busy", {31'd0, bus.inReady}, 32'd0);
      chk("to_early", {31'd0, bus.memTimeout}, 32'd0);
      cyc;
    end
    chk("to_pulse", {31'd0, bus.memTimeout}, 32'd1);
    chk("to_rdy", {31'd0, bus.inReady}, 32'd1);
    chk("to_we", {31'd0, bus.writeEnable}, 32'd0);
    cyc;
    chk("to_once", {31'd0, bus.memTimeout}, 32'd0);
    bus.memRespValid = 1'b1;
    bus.memRespData = 32'h55555555;
    cyc;
    bus.memRespValid = 1'b0;
    chk("late_we", {31'd0, bus.writeEnable}, 32'd0);
    chk("late_rdy", {31'd0, bus.inReady}, 32'd1);
    // flush with response in the same cycle
    issue_load(3'b010, 5'd10, 32'h5000);
    cyc;
    bus.flush = 1'b1;
    bus.memRespValid = 1'b1;
    cyc;
    bus.flush = 1'b0;
    bus.memRespValid = 1'b0;
    chk("fl_we", {31'd0, bus.writeEnable}, 32'd0);
    chk("fl_rdy", {31'd0, bus.inReady}, 32'd1);
    // flush in IDLE drops the transfer
    alu(5'd11, 32'hCAFEF00D);
    bus.flush = 1'b1;
    cyc;
    bus.flush = 1'b0;
    bus.inValid = 1'b0;
    chk("fli_we", {31'd0, bus.writeEnable}, 32'd0);
    // reset mid-wait
    issue_load(3'b010, 5'd13, 32'h6000);
    cyc;
    chk("rm_busy", {31'd0, bus.inReady}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_rdy", {31'd0, bus.inReady}, 32'd1);
    chk("rm_data", bus.writeDate, 32'd0);
    chk("rm_addr", {27'd0, bus.writeAddr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.memRespValid = 1'b1;
    cyc;
    bus.memRespValid = 1'b0;
    chk("rm_we", {31'd0, bus.writeEnable}, 32'd0);
    chk("rm_rdy2", {31'd0, bus.inReady}, 32'd1);
    alu(5'd14, 32'h0000ABCD);
    cyc;
    bus.inValid = 1'b0;
    chk("post_we", {31'd0, bus.writeEnable}, 32'd1);
    chk("post_data", bus.writeDate, 32'h0000ABCD);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
